zece_datapath: RTL
==================

// Module: zece_datapath
// PURPOSE
//  Operational unit driven by the 11-state control automaton. It executes the micro-op
//  strobes t1..t9 on registers A (accumulator), B (operand) and C (down-counter).
//  It returns condition flags x and y, which the automaton samples on its next clk edge.
//  It sits beside the automaton, shares clk/res, and closes the control<->data loop.
// PARAMETERS
//  W   8  data width of A, B, din, dout
//  CW  4  width of counter C (loaded from din[CW-1:0])
// PORTS
//  clk       in   1   rising-edge clock
//  res       in   1   synchronous, active-high reset
//  t1..t9    in   1   micro-op strobes (level, sampled at posedge clk; several may be high)
//  din       in   W   load data for B / C
//  x         out  1   A negative: A[W-1] (combinational from registered A)
//  y         out  1   counter exhausted: C == 0 (combinational from registered C)
//  dout      out  W   captured copy of A
//  dout_vld  out  1   one-cycle pulse: dout updated
//  ovf       out  1   sticky signed overflow of A arithmetic
//  err       out  1   sticky protocol error (t7 != t8)
// BEHAVIOUR
//  Reset (res=1 at posedge, overrides every strobe, including mid-operation):
//   - A=B=C=0, dout=0, dout_vld=0, ovf=0, err=0; hence x=0, y=1.
//  Micro-ops, each taking effect at the posedge where it is sampled:
//   - t1: A<=A+B         t5: A<=A-B          t9: A<=0
//   - t4: B<=B<<1 (MSB dropped, LSB=0)       t7: B<=din
//   - t8: C<=din[CW-1:0]                     t2: C<=C-1, saturating at 0 (no wrap)
//   - t3: dout<=A, dout_vld=1 next cycle     t6: clear ovf
//  Priority on A: t9 > t5 > t1 (only the winning op is applied).
//  Priority on B: t7 > t4.   Priority on C: t8 > t2.
//  Same-edge reads use pre-edge values:
//   - t3 with t1 captures old A.
//   - t1 with t4 adds old B.
//  Arithmetic is modulo 2^W.
//  ovf:
//   - sets when the applied t1/t5 result overflows (two's-complement sign rule).
//   - set has priority over a simultaneous t6 clear.
//   - a t1/t5 masked by t9 never sets ovf.
//  err: sets when t7 XOR t8 at a sampled edge; cleared only by res.
//  dout_vld: high exactly one cycle per t3; back-to-back t3 gives a continuous high.
//  Flag latency: strobe at edge k -> register update at edge k -> x/y valid after edge k.
//   The automaton uses them at edge k+1. There is no extra pipeline stage.
//  No internal FSM beyond the registers; all state is A, B, C, dout, dout_vld, ovf, err.
// TESTING
//  1 res=1 with t1..t9=1, din=FF for 2 clks -> A=B=C=0, dout_vld=0, ovf=err=0,
//    x=0, y=1.
//  2 t7=t8=1, din=05 -> B=05, C=5, y=0, err=0. Then t1 x3 -> A=0F.
//    Then t2 x5 -> y=1 after the 5th; a 6th t2 keeps C=0.
//  3 Priority with A=03, B=05:
//    - t1+t5+t9 -> A=00.
//    - then t1+t5 -> A=FB (A-B wins), x=1.
//    - then t4+t7 with din=09 -> B=09.
//  4 A=70, B=20, t1 -> A=90, ovf=1, x=1. t6 -> ovf=0.
//    t6+t1 with A=70, B=20 -> ovf stays 1.
//  5 A=2A, B=01, t3+t1 -> dout=2A, dout_vld high one cycle, A=2B.
//    t3 on two consecutive cycles -> dout_vld high two cycles.
//  6 t7 alone -> err=1, B loaded, C unchanged; err holds through later
//    t7+t8 until res=1.

Source files
------------

// File: rtl/zece_datapath.sv
// Datapath beside the control automaton: A/B/C registers driven by micro-op strobes t1..t9,
// returning condition flags x (A negative) and y (counter exhausted) for the next edge.
module zece_datapath #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         t1,
  input  logic         t2,
  input  logic         t3,
  input  logic         t4,
  input  logic         t5,
  input  logic         t6,
  input  logic         t7,
  input  logic         t8,
  input  logic         t9,
  input  logic [W-1:0] din,
  output logic         x,
  output logic         y,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         ovf,
  output logic         err
);

  localparam logic [W-1:0]  A_ZERO = {W{1'b0}};
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // Two's-complement overflow: operands of equal sign giving a result of the other sign.
  function automatic logic add_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // For a-b the operand signs must differ for the result to leave the range.
  function automatic logic sub_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] d);
    return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  logic [W-1:0]  a_r, b_r, dout_r;
  logic [CW-1:0] c_r;
  logic          vld_r, ovf_r, err_r;

  logic [W-1:0]  a_nxt_s, b_nxt_s, sum_s, dif_s;
  logic [CW-1:0] c_nxt_s;
  logic          ovf_set_s, ovf_nxt_s;

  // Next-state selection with the A/B/C priority chains; all reads use pre-edge values.
  always_comb begin
    sum_s     = a_r + b_r;
    dif_s     = a_r - b_r;
    a_nxt_s   = a_r;
    b_nxt_s   = b_r;
    c_nxt_s   = c_r;
    ovf_set_s = 1'b0;
    if (t9) begin
      a_nxt_s = A_ZERO;
    end else if (t5) begin
      a_nxt_s   = dif_s;
      ovf_set_s = sub_ovf(a_r, b_r, dif_s);
    end else if (t1) begin
      a_nxt_s   = sum_s;
      ovf_set_s = add_ovf(a_r, b_r, sum_s);
    end else begin
      a_nxt_s = a_r;
    end
    if (t7) begin
      b_nxt_s = din;
    end else if (t4) begin
      b_nxt_s = {b_r[W-2:0], 1'b0};
    end else begin
      b_nxt_s = b_r;
    end
    if (t8) begin
      c_nxt_s = din[CW-1:0];
    end else if (t2 && (c_r != C_ZERO)) begin
      c_nxt_s = c_r - C_ONE;
    end else begin
      c_nxt_s = c_r;
    end
    // A fresh overflow wins over a same-edge clear.
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (t6) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State registers with synchronous reset overriding every strobe.
  always_ff @(posedge clk) begin
    if (res) begin
      a_r    <= A_ZERO;
      b_r    <= A_ZERO;
      c_r    <= C_ZERO;
      dout_r <= A_ZERO;
      vld_r  <= 1'b0;
      ovf_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      a_r    <= a_nxt_s;
      b_r    <= b_nxt_s;
      c_r    <= c_nxt_s;
      dout_r <= t3 ? a_r : dout_r;
      vld_r  <= t3;
      ovf_r  <= ovf_nxt_s;
      err_r  <= err_r | (t7 ^ t8);
    end
  end

  assign x        = a_r[W-1];
  assign y        = (c_r == C_ZERO);
  assign dout     = dout_r;
  assign dout_vld = vld_r;
  assign ovf      = ovf_r;
  assign err      = err_r;

endmodule
